// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared definitions for the boot-time program loader: the loader FSM state
// encoding, the default frame start marker, and the widths of the frame
// fields and instruction-memory write port.
package prog_loader_pkg;

    localparam int BYTE_W = 8;
    localparam int WORD_W = 16;
    localparam int LEN_W  = 16;
    localparam int ADDR_W = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_H,
        LEN_L,
        DATA_H,
        DATA_L,
        CSUM,
        DONE,
        ERR
    } loaderState_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader
// Boot-time program loader. Receives a framed byte stream
// (SYNC, LEN_H, LEN_L, 2*N payload bytes, CSUM) over a valid/ready handshake,
// packs payload bytes big-endian into 16-bit words and writes them to
// consecutive instruction-memory addresses starting at BASE_ADDR. The CPU is
// held until a frame with a matching XOR checksum has been fully written.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - synchronous active-low reset
//   start      - one-cycle pulse, rearms the loader from DONE or ERR
//   in_valid   - byte source has a byte on in_data
//   in_data    - stream byte
//   in_ready   - loader accepts a byte this cycle (state decode only)
//   imem_we    - registered instruction-memory write strobe, one cycle per word
//   imem_addr  - registered write address
//   imem_wdata - registered write data
//   cpu_hold   - high in every state except DONE
//   done       - load complete with good checksum
//   err        - frame rejected (oversize length or bad checksum)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int unsigned       MAX_WORDS = 256,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [31:0] MAX_WORDS_W = 32'(MAX_WORDS);

    loaderState_t      state;
    loaderState_t      nextState;
    logic [LEN_W-1:0]  lenReg;
    logic [LEN_W-1:0]  lenFull;
    logic [LEN_W-1:0]  wordCount;
    logic [BYTE_W-1:0] xorAcc;
    logic [BYTE_W-1:0] highByte;
    logic              accept;
    logic              lastWord;
    logic              lenTooBig;

    // Handshake and status are pure decodes of the registered state so that
    // in_ready never depends combinationally on in_valid.
    always_comb begin
        in_ready = (state != DONE) && (state != ERR);
        cpu_hold = (state != DONE);
        done     = (state == DONE);
        err      = (state == ERR);
        accept   = in_valid && in_ready;
    end

    // The length is only complete while the LEN_L byte is on the bus, so the
    // range checks combine the stored high byte with the live low byte.
    // lastWord compares the count after this word against the frame length.
    always_comb begin
        lenFull   = {lenReg[LEN_W-1:BYTE_W], in_data};
        lenTooBig = {16'h0000, lenFull} > MAX_WORDS_W;
        lastWord  = (wordCount + 16'd1) == lenReg;
    end

    // Next-state logic. Every streaming state advances only on an accepted
    // byte, so the loader parks in place while in_valid is low. A sync value
    // inside a frame is ordinary data because only IDLE looks for it.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept && (in_data == SYNC_BYTE)) nextState = LEN_H;
            end
            LEN_H: begin
                if (accept) nextState = LEN_L;
            end
            LEN_L: begin
                if (accept) begin
                    if (lenTooBig)               nextState = ERR;
                    else if (lenFull == 16'd0)   nextState = CSUM;
                    else                         nextState = DATA_H;
                end
            end
            DATA_H: begin
                if (accept) nextState = DATA_L;
            end
            DATA_L: begin
                if (accept) nextState = lastWord ? CSUM : DATA_H;
            end
            CSUM: begin
                if (accept) nextState = (in_data == xorAcc) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (start) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // State register and datapath. The write strobe defaults low each cycle
    // and is raised only by an accepted DATA_L byte, giving a one-cycle pulse
    // in the following cycle. Address and data hold their last value between
    // writes. Reset leaves memory contents alone; only loader state clears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lenReg     <= '0;
            wordCount  <= '0;
            xorAcc     <= '0;
            highByte   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state   <= nextState;
            imem_we <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (in_data == SYNC_BYTE) xorAcc <= '0;
                    end
                    LEN_H: begin
                        lenReg <= {in_data, 8'h00};
                    end
                    LEN_L: begin
                        lenReg <= lenFull;
                        if (nextState == DATA_H) wordCount <= '0;
                    end
                    DATA_H: begin
                        highByte <= in_data;
                        xorAcc   <= xorAcc ^ in_data;
                    end
                    DATA_L: begin
                        xorAcc     <= xorAcc ^ in_data;
                        imem_we    <= 1'b1;
                        imem_addr  <= BASE_ADDR + wordCount;
                        imem_wdata <= {highByte, in_data};
                        wordCount  <= wordCount + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Scoreboard bench for prog_loader. Two loaders share one byte stream: one
// at the default base address 0x0000 and one at 0xFFFF so address wrap is
// exercised on every frame. Expected writes are queued when a frame is
// issued; a monitor pops and compares whenever a write strobe appears.
module tb_prog_loader;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        inReady0, imemWe0, cpuHold0, done0, err0;
    logic [15:0] imemAddr0, imemWdata0;
    logic        inReady1, imemWe1, cpuHold1, done1, err1;
    logic [15:0] imemAddr1, imemWdata1;

    int          assertCount;
    int          failCount;
    wr_t         expQ0[$];
    wr_t         expQ1[$];
    wr_t         pop0;
    wr_t         pop1;
    logic [7:0]  frameQ[$];

    prog_loader dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (inReady0),
        .imem_we    (imemWe0),
        .imem_addr  (imemAddr0),
        .imem_wdata (imemWdata0),
        .cpu_hold   (cpuHold0),
        .done       (done0),
        .err        (err0)
    );

    prog_loader #(.BASE_ADDR(16'hFFFF)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (inReady1),
        .imem_we    (imemWe1),
        .imem_addr  (imemAddr1),
        .imem_wdata (imemWdata1),
        .cpu_hold   (cpuHold1),
        .done       (done1),
        .err        (err1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still reports and ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Queue the write each loader should perform for word index idx.
    task automatic expectWord(input logic [15:0] idx, input logic [15:0] data);
        wr_t e;
        e.data = data;
        e.addr = 16'h0000 + idx;
        expQ0.push_back(e);
        e.addr = 16'hFFFF + idx;
        expQ1.push_back(e);
    endtask

    // Monitor: every write strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (imemWe0) begin
            if (expQ0.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_write0: got write addr 0x%0h data 0x%0h, required none",
                         imemAddr0, imemWdata0);
            end else begin
                pop0 = expQ0.pop_front();
                checkVal("write0_addr", 32'(imemAddr0), 32'(pop0.addr));
                checkVal("write0_data", 32'(imemWdata0), 32'(pop0.data));
            end
        end
        if (imemWe1) begin
            if (expQ1.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_write1: got write addr 0x%0h data 0x%0h, required none",
                         imemAddr1, imemWdata1);
            end else begin
                pop1 = expQ1.pop_front();
                checkVal("write1_addr", 32'(imemAddr1), 32'(pop1.addr));
                checkVal("write1_data", 32'(imemWdata1), 32'(pop1.data));
            end
        end
    end

    // Present one byte after 'gap' idle cycles; called and returns on a
    // negedge, with the accepting posedge in between.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        checkVal("in_ready_before_byte", {30'd0, inReady1, inReady0}, 32'h3);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Send frameQ; with gaps enabled the payload bytes get random stalls.
    task automatic sendFrame(input bit withGaps);
        int n;
        n = frameQ.size();
        for (int i = 0; i < n; i++) begin
            if (withGaps && i > 2 && i < n - 1) applyStimulus(frameQ[i], int'($urandom_range(0, 3)));
            else                                applyStimulus(frameQ[i], 0);
        end
    endtask

    task automatic checkOutput(input string name, input logic expDone, input logic expErr);
        checkVal({name, "_done"}, {30'd0, done1, done0}, {30'd0, expDone, expDone});
        checkVal({name, "_err"}, {30'd0, err1, err0}, {30'd0, expErr, expErr});
        checkVal({name, "_cpu_hold"}, {30'd0, cpuHold1, cpuHold0}, {30'd0, !expDone, !expDone});
        checkVal({name, "_in_ready"}, {30'd0, inReady1, inReady0},
                 {30'd0, !(expDone || expErr), !(expDone || expErr)});
    endtask

    // All queued writes must have been observed; waits off the negedge so
    // the monitor has already run.
    task automatic checkQueues(input string name);
        #1;
        checkVal({name, "_pending_writes0"}, 32'(expQ0.size()), 32'd0);
        checkVal({name, "_pending_writes1"}, 32'(expQ1.size()), 32'd0);
    endtask

    task automatic pulseStart(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput(name, 1'b0, 1'b0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkVal({name, "_we"}, {30'd0, imemWe1, imemWe0}, 32'd0);
        checkVal({name, "_addr0"}, 32'(imemAddr0), 32'd0);
        checkVal({name, "_addr1"}, 32'(imemAddr1), 32'd0);
        checkVal({name, "_wdata0"}, 32'(imemWdata0), 32'd0);
        checkVal({name, "_wdata1"}, 32'(imemWdata1), 32'd0);
        checkOutput(name, 1'b0, 1'b0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] normal load");
        expectWord(16'd0, 16'h1234);
        expectWord(16'd1, 16'hABCD);
        frameQ = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        sendFrame(1'b0);
        checkOutput("normal", 1'b1, 1'b0);
        checkQueues("normal");
        pulseStart("normal_rearm");

        $display("[TB] bad checksum");
        expectWord(16'd0, 16'h1234);
        expectWord(16'd1, 16'hABCD);
        frameQ = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        sendFrame(1'b0);
        checkOutput("badcsum", 1'b0, 1'b1);
        checkQueues("badcsum");
        pulseStart("badcsum_rearm");

        $display("[TB] oversize length");
        frameQ = '{8'hA5, 8'h01, 8'h01};
        sendFrame(1'b0);
        checkOutput("oversize", 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checkQueues("oversize");
        pulseStart("oversize_rearm");

        $display("[TB] empty frame");
        frameQ = '{8'hA5, 8'h00, 8'h00, 8'h00};
        sendFrame(1'b0);
        checkOutput("empty", 1'b1, 1'b0);
        checkQueues("empty");
        pulseStart("empty_rearm");

        $display("[TB] garbage and stalls");
        expectWord(16'd0, 16'h1234);
        expectWord(16'd1, 16'hABCD);
        frameQ = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        sendFrame(1'b1);
        checkOutput("garbage", 1'b1, 1'b0);
        checkQueues("garbage");
        pulseStart("garbage_rearm");

        $display("[TB] sync value inside payload");
        expectWord(16'd0, 16'hA500);
        frameQ = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'h00, 8'hA5};
        sendFrame(1'b0);
        checkOutput("midsync", 1'b1, 1'b0);
        checkQueues("midsync");
        pulseStart("midsync_rearm");

        $display("[TB] reset mid-frame");
        expectWord(16'd0, 16'h1234);
        frameQ = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
        sendFrame(1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetOutputs("midreset");
        rst_n = 1'b1;
        checkQueues("midreset");
        expectWord(16'd0, 16'h1234);
        expectWord(16'd1, 16'hABCD);
        frameQ = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        sendFrame(1'b0);
        checkOutput("afterreset", 1'b1, 1'b0);
        checkQueues("afterreset");

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that writes the 16-bit instruction memory the single-cycle CPU reads. It accepts a framed byte stream over a valid/ready handshake, packs bytes into big-endian 16-bit words and writes them to consecutive instruction addresses. It holds the CPU stalled until a frame with a good checksum has been fully written. It sits between the host/UART byte source and the instruction memory's write port; the CPU keeps the read port.

## Interface
- `BASE_ADDR`, 16'h0000: instruction address of the first loaded word.
- `MAX_WORDS`, 256: largest accepted word count; any larger length is an error.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse that rearms the loader from DONE or ERR.
- `in_valid` in 1: byte source has data.
- `in_data` in 8: byte.
- `in_ready` out 1: loader accepts a byte this cycle. A byte transfers when `in_valid && in_ready`.
- `imem_we` out 1: instruction memory write strobe, one cycle per word.
- `imem_addr` out 16: write address.
- `imem_wdata` out 16: write data.
- `cpu_hold` out 1: holds the CPU PC/state while high.
- `done` out 1: load complete, checksum good.
- `err` out 1: frame rejected.

## Operation
- Frame format: `SYNC_BYTE`, `LEN_H`, `LEN_L`, then 2·N payload bytes (high byte first per word), then `CSUM`.
  - N = {LEN_H, LEN_L}.
  - `CSUM` is the XOR of all payload bytes; it is 8'h00 when N = 0.
- States and transitions:
  - IDLE: non-sync bytes are consumed and discarded; `SYNC_BYTE` goes to LEN_H.
  - LEN_H goes to LEN_L.
  - LEN_L:
    - N > MAX_WORDS goes to ERR.
    - N = 0 goes to CSUM.
    - Otherwise goes to DATA_H.
  - DATA_H goes to DATA_L.
  - DATA_L goes to CSUM if this was the last word, otherwise to DATA_H.
  - CSUM: a match goes to DONE, a mismatch goes to ERR.
  - DONE and ERR return to IDLE on `start`; they ignore the stream otherwise.
- Counters:
  - 16-bit word counter, cleared on entry to DATA_H from LEN_L.
  - Running XOR, cleared on SYNC.
- Write address is `BASE_ADDR` + word index, modulo 2^16, so it wraps silently past 16'hFFFF.
- `in_ready` is 1 in IDLE, LEN_H, LEN_L, DATA_H, DATA_L and CSUM; it is 0 in DONE and ERR.
- `cpu_hold` is 1 in every state except DONE.
- `done` is 1 only in DONE; `err` is 1 only in ERR.
- A checksum error does not undo words already written; the CPU stays held.
- `start` has no effect outside DONE/ERR.
- A SYNC_BYTE value seen mid-frame is treated as ordinary data, not resynchronisation.

## Timing
- Reset values:
  - state = IDLE.
  - `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0.
  - `cpu_hold` = 1, `done` = 0, `err` = 0.
  - Counters and XOR = 0.
- `rst_n` low mid-frame aborts the frame. The next cycle is IDLE, and partial writes remain in memory.
- `in_ready` is a decode of the registered state only, with no combinational path from `in_valid`.
- Stalls: the loader waits in the current state indefinitely while `in_valid` = 0.
- Write latency:
  - `imem_we`/`imem_addr`/`imem_wdata` are registered.
  - The strobe asserts in the cycle after the DATA_L byte is accepted, for exactly one cycle.
  - Back-to-back bytes give at most one write every 2 cycles.
- Completion: `done` and `cpu_hold` deassert in the cycle after the CSUM byte is accepted. The last word's `imem_we` occurs no later than that same cycle.
- `start` and `rst_n` low in the same cycle: reset wins.

## Structure
- Shared package `prog_loader_pkg` contains:
  - the state enum (IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CSUM, DONE, ERR);
  - the default `SYNC_BYTE`;
  - the frame-field width constants.
- No sub-module; one FSM plus datapath registers. Estimated 150–250 lines.

## Test plan
- Normal load:
  - Stimulus: A5 00 02 12 34 AB CD, CSUM 0x12^0x34^0xAB^0xCD = 0x40.
  - Required: writes 0x1234 at addr 0 and 0xABCD at addr 1; `done` = 1, `cpu_hold` = 0, `err` = 0.
- Bad checksum:
  - Stimulus: the same frame with CSUM 0x41.
  - Required: both words written, `err` = 1, `cpu_hold` = 1. Then `start` returns to IDLE with `err` = 0.
- Oversize and empty frames:
  - Stimulus: N = 0x0101 with MAX_WORDS = 256.
  - Required: ERR right after LEN_L, no writes.
  - Stimulus: N = 0 with CSUM 00.
  - Required: DONE, no writes.
- Garbage and stalls:
  - Stimulus: bytes 00 FF before A5, plus random `in_valid` gaps inside the payload.
  - Required: garbage discarded, identical writes and completion.
- Reset mid-frame:
  - Stimulus: `rst_n` low after the first payload word.
  - Required: next cycle IDLE with all outputs at reset values. A following full frame loads correctly.
- Address base and wrap:
  - Stimulus: BASE_ADDR = 16'hFFFF with N = 2.
  - Required: writes to addr 0xFFFF, then 0x0000.
